// File: rtl/serial_chunk_adder.sv
// Multi-cycle two's-complement adder/subtractor: adds CHUNK bits per clock through a
// registered inter-chunk carry, reporting sum, carry-out and signed overflow.
module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_chunk_adder: CHUNK must be >= 1 and divide WIDTH");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Returns {carry_out, carry_into_msb, chunk_sum}; carry into the MSB is recovered
    // from the MSB sum bit so no separate partial adder is needed.
    function automatic logic [CHUNK+1:0] chunk_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic [CHUNK:0] t;
        t = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
        return {t[CHUNK], t[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1], t[CHUNK-1:0]};
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [CHUNK+1:0]       chunk_res_s;
    logic [WIDTH+CHUNK-1:0] acc_wide_s;
    logic [WIDTH-1:0]       acc_shift_s;

    assign chunk_res_s = chunk_add(ra_q[CHUNK-1:0], rb_q[CHUNK-1:0], c_q);
    assign acc_wide_s  = {chunk_res_s[CHUNK-1:0], acc_q};
    assign acc_shift_s = acc_wide_s[WIDTH+CHUNK-1:CHUNK];

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and result next-state: operand capture in IDLE, one chunk per RUN edge
    always_comb begin
        cnt_d  = cnt_q;
        c_d    = c_q;
        ra_d   = ra_q;
        rb_d   = rb_q;
        acc_d  = acc_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    ra_d  = a_i;
                    rb_d  = sub_i ? ~b_i : b_i;
                    c_d   = sub_i ? 1'b1 : cin_i;
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RUN: begin
                ra_d  = ra_q >> CHUNK;
                rb_d  = rb_q >> CHUNK;
                c_d   = chunk_res_s[CHUNK+1];
                acc_d = acc_shift_s;
                if (cnt_q == LAST_CNT) begin
                    sum_d  = acc_shift_s;
                    cout_d = chunk_res_s[CHUNK+1];
                    ovf_d  = chunk_res_s[CHUNK+1] ^ chunk_res_s[CHUNK];
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and result registers; reset abandons any operation in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= {CW{1'b0}};
            c_q    <= 1'b0;
            ra_q   <= {WIDTH{1'b0}};
            rb_q   <= {WIDTH{1'b0}};
            acc_q  <= {WIDTH{1'b0}};
            sum_q  <= {WIDTH{1'b0}};
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            c_q    <= c_d;
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            acc_q  <= acc_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;
    assign done_o = done_q;
    assign busy_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder across CHUNK = 2, 4, 8 and 1 at WIDTH = 8.
module tb_serial_chunk_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       start_r [4];
    logic [7:0] sum_w   [4];
    logic       cout_w  [4];
    logic       ovf_w   [4];
    logic       busy_w  [4];
    logic       done_w  [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_r[0]), .sub_i(sub), .cin_i(cin),
        .a_i(a), .b_i(b), .sum_o(sum_w[0]), .cout_o(cout_w[0]), .ovf_o(ovf_w[0]),
        .busy_o(busy_w[0]), .done_o(done_w[0]));
    serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_r[1]), .sub_i(sub), .cin_i(cin),
        .a_i(a), .b_i(b), .sum_o(sum_w[1]), .cout_o(cout_w[1]), .ovf_o(ovf_w[1]),
        .busy_o(busy_w[1]), .done_o(done_w[1]));
    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_r[2]), .sub_i(sub), .cin_i(cin),
        .a_i(a), .b_i(b), .sum_o(sum_w[2]), .cout_o(cout_w[2]), .ovf_o(ovf_w[2]),
        .busy_o(busy_w[2]), .done_o(done_w[2]));
    serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_r[3]), .sub_i(sub), .cin_i(cin),
        .a_i(a), .b_i(b), .sum_o(sum_w[3]), .cout_o(cout_w[3]), .ovf_o(ovf_w[3]),
        .busy_o(busy_w[3]), .done_o(done_w[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge (E0); returns just after E0.
    task automatic launch(input int k, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic cv);
        a = av;
        b = bv;
        sub = sv;
        cin = cv;
        start_r[k] = 1'b1;
        tick();
        start_r[k] = 1'b0;
    endtask

    // Wait (bounded) for done, checking busy, latency, results and the done pulse width.
    task automatic finish_op(input int k, input int lat, input logic [7:0] es,
                             input logic ec, input logic eo, input string tag);
        int n;
        n = 0;
        while (done_w[k] !== 1'b1 && n < 40) begin
            chk({tag, "_busy_run"}, 32'(busy_w[k]), 32'd1);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_sum"}, 32'(sum_w[k]), 32'(es));
        chk({tag, "_cout"}, 32'(cout_w[k]), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf_w[k]), 32'(eo));
        chk({tag, "_busy_done"}, 32'(busy_w[k]), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done_w[k]), 32'd0);
    endtask

    initial begin
        logic [7:0] av;
        logic [7:0] bv;
        logic [8:0] ev;
        logic       seen_done;

        rst_n = 1'b0;
        sub = 1'b0;
        cin = 1'b0;
        a = 8'h00;
        b = 8'h00;
        for (int i = 0; i < 4; i++) start_r[i] = 1'b0;
        #1;
        chk("reset_sum", 32'(sum_w[0]), 32'd0);
        chk("reset_busy", 32'(busy_w[0]), 32'd0);
        chk("reset_done", 32'(done_w[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Add with full carry out, CHUNK=2
        launch(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        finish_op(0, 4, 8'h00, 1'b1, 1'b0, "add_ff_01");

        // Subtract with borrow and without; cin ignored in sub mode
        launch(0, 8'h05, 8'h07, 1'b1, 1'b1);
        finish_op(0, 4, 8'hFE, 1'b0, 1'b0, "sub_05_07");
        launch(0, 8'h07, 8'h05, 1'b1, 1'b0);
        finish_op(0, 4, 8'h02, 1'b1, 1'b0, "sub_07_05");

        // Signed overflow cases, CHUNK=4
        launch(1, 8'h7F, 8'h01, 1'b0, 1'b0);
        finish_op(1, 2, 8'h80, 1'b0, 1'b1, "ovf_add");
        launch(1, 8'h80, 8'h01, 1'b1, 1'b0);
        finish_op(1, 2, 8'h7F, 1'b1, 1'b1, "ovf_sub");

        // Start while busy is ignored; start on the done cycle is accepted
        launch(0, 8'h10, 8'h20, 1'b0, 1'b0);
        tick();
        a = 8'hFF;
        b = 8'hFF;
        start_r[0] = 1'b1;
        tick();
        start_r[0] = 1'b0;
        tick();
        tick();
        chk("ign_done", 32'(done_w[0]), 32'd1);
        chk("ign_sum", 32'(sum_w[0]), 32'h30);
        chk("ign_busy", 32'(busy_w[0]), 32'd0);
        launch(0, 8'h01, 8'h01, 1'b0, 1'b0);
        chk("b2b_accept", 32'(busy_w[0]), 32'd1);
        finish_op(0, 4, 8'h02, 1'b0, 1'b0, "b2b");

        // Asynchronous reset mid-RUN clears outputs and suppresses done
        launch(0, 8'h0F, 8'h01, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum", 32'(sum_w[0]), 32'd0);
        chk("arst_cout", 32'(cout_w[0]), 32'd0);
        chk("arst_ovf", 32'(ovf_w[0]), 32'd0);
        chk("arst_busy", 32'(busy_w[0]), 32'd0);
        chk("arst_done", 32'(done_w[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_done = seen_done | done_w[0];
        end
        chk("arst_no_done", 32'(seen_done), 32'd0);
        launch(0, 8'h01, 8'h02, 1'b0, 1'b0);
        finish_op(0, 4, 8'h03, 1'b0, 1'b0, "post_rst");

        // Random add with cin=1 at CHUNK=8 (latency 1) and CHUNK=1 (latency 8)
        for (int k = 2; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                av = 8'($urandom);
                bv = 8'($urandom);
                ev = {1'b0, av} + {1'b0, bv} + 9'd1;
                launch(k, av, bv, 1'b0, 1'b1);
                finish_op(k, (k == 2) ? 1 : 8, ev[7:0], ev[8],
                          (av[7] == bv[7]) && (ev[7] != av[7]),
                          (k == 2) ? "rand_c8" : "rand_c1");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
